// File: rtl/memctrl_pkg.sv
// Shared encodings for the multi-port byte-serial memory controller:
// request type fields, FSM states and the default IO window base.
package memctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int TYPE_WR_BIT  = 3;
  localparam int TYPE_UNS_BIT = 2;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT,
    ST_DONE
  } state_e;

  // The reserved size code 11 falls through to a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Request arbiter: one-hot grant from a request mask.
// MEMCTRL_RR_ARB_EN selects round-robin; otherwise the lowest index wins.
module mem_rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 advance,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef MEMCTRL_RR_ARB_EN
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  // Search starts at the pointer and wraps, so the last winner goes to the back.
  always_comb begin
    int   idx;
    logic found;
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr_reg) + i) % NUM_PORTS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        ptr_next   = PTR_W'((idx + 1) % NUM_PORTS);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= ptr_next;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk_in, rst_in, advance};

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/memctrl_mp.sv
// memctrl_mp: arbitrates NUM_PORTS requesters onto one 8-bit RAM/IO bus and
// serialises byte/half/word accesses. Define MEMCTRL_RR_ARB_EN for round-robin.
module memctrl_mp
  import memctrl_pkg::*;
#(
  parameter int                    NUM_PORTS = 2,
  parameter int                    ADDR_W    = 32,
  parameter logic [NUM_PORTS-1:0]  RVC_MASK  = NUM_PORTS'(2'b10),
  parameter logic [ADDR_W-1:0]     IO_BASE   = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush,
  input  logic                        io_buffer_full,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_a,
  output logic                        mem_wr,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0]     req_wdata,
  input  logic [NUM_PORTS*4-1:0]      req_type,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [31:0]                 resp_rdata,
  output logic                        resp_is_c
);

  state_e                state_reg, state_next;
  logic [1:0]            k_reg, k_next;
  logic [ADDR_W-1:0]     addr_reg, addr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic                  wr_reg, wr_next;
  logic                  uns_reg, uns_next;
  logic [1:0]            size_reg, size_next;
  logic                  rvc_reg, rvc_next;
  logic [NUM_PORTS-1:0]  port_reg, port_next;
  logic [31:0]           buf_reg, buf_next;
  logic [ADDR_W-1:0]     mem_a_reg, mem_a_next;
  logic [7:0]            mem_dout_reg, mem_dout_next;
  logic                  mem_wr_reg, mem_wr_next;
  logic [NUM_PORTS-1:0]  resp_valid_reg, resp_valid_next;
  logic [31:0]           resp_rdata_reg, resp_rdata_next;
  logic                  resp_is_c_reg, resp_is_c_next;

  logic [NUM_PORTS-1:0]  blocked, arb_req, grant;
  logic                  accept;
  logic [ADDR_W-1:0]     sel_addr;
  logic [31:0]           sel_wdata;
  logic [3:0]            sel_type;

  // Only stores into the IO window wait on a full UART buffer.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
    assign blocked[gi] = io_buffer_full && req_type[gi*4 + TYPE_WR_BIT]
                         && (req_addr[gi*ADDR_W +: ADDR_W] >= IO_BASE);
  end

  assign arb_req = (rdy_in && !flush && (state_reg == ST_IDLE || state_reg == ST_DONE))
                   ? (req_valid & ~blocked) : '0;
  assign accept  = |grant;

  mem_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .advance (accept),
    .req     (arb_req),
    .grant   (grant)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_type  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*32 +: 32];
        sel_type  = req_type[i*4 +: 4];
      end
    end
  end

  always_comb begin
    logic [1:0]  k_inc;
    logic [1:0]  last_idx;
    logic        rvc_stop;
    logic [31:0] full_word;
    state_next      = state_reg;
    k_next          = k_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    wr_next         = wr_reg;
    uns_next        = uns_reg;
    size_next       = size_reg;
    rvc_next        = rvc_reg;
    port_next       = port_reg;
    buf_next        = buf_reg;
    mem_a_next      = mem_a_reg;
    mem_dout_next   = mem_dout_reg;
    mem_wr_next     = mem_wr_reg;
    resp_valid_next = '0;
    resp_rdata_next = resp_rdata_reg;
    resp_is_c_next  = resp_is_c_reg;
    k_inc           = k_reg + 2'd1;
    last_idx        = 2'(size_bytes(size_reg) - 3'd1);
    // mem_din carries byte 0 while byte index 1 is on the bus.
    rvc_stop        = rvc_reg && (k_reg == 2'd1) && (mem_din[1:0] != 2'b11);
    full_word       = buf_reg;
    full_word[{k_reg, 3'b000} +: 8] = mem_din;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (accept) begin
          state_next    = ST_XFER;
          k_next        = 2'd0;
          addr_next     = sel_addr;
          wdata_next    = sel_wdata;
          wr_next       = sel_type[TYPE_WR_BIT];
          uns_next      = sel_type[TYPE_UNS_BIT];
          size_next     = sel_type[1:0];
          rvc_next      = (|(grant & RVC_MASK)) && !sel_type[TYPE_WR_BIT] && sel_type[1];
          port_next     = grant;
          buf_next      = '0;
          mem_a_next    = sel_addr;
          mem_dout_next = sel_wdata[7:0];
          mem_wr_next   = sel_type[TYPE_WR_BIT];
        end
      end
      ST_XFER: begin
        if (flush && !wr_reg) begin
          state_next = ST_IDLE;
        end else begin
          if (!wr_reg && k_reg != 2'd0) buf_next[{k_reg - 2'd1, 3'b000} +: 8] = mem_din;
          if (k_reg == last_idx || rvc_stop) begin
            mem_wr_next = 1'b0;
            rvc_next    = rvc_stop;
            if (wr_reg) begin
              state_next      = ST_DONE;
              resp_valid_next = port_reg;
              resp_is_c_next  = 1'b0;
            end else begin
              state_next = ST_WAIT;
            end
          end else begin
            k_next        = k_inc;
            mem_a_next    = addr_reg + ADDR_W'(k_inc);
            mem_dout_next = wdata_reg[{k_inc, 3'b000} +: 8];
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          state_next      = ST_DONE;
          resp_valid_next = port_reg;
          resp_is_c_next  = rvc_reg;
          if (rvc_reg) begin
            resp_rdata_next = {16'h0000, full_word[15:0]};
          end else begin
            case (size_reg)
              SZ_B:    resp_rdata_next = {{24{!uns_reg && full_word[7]}}, full_word[7:0]};
              SZ_H:    resp_rdata_next = {{16{!uns_reg && full_word[15]}}, full_word[15:0]};
              default: resp_rdata_next = full_word;
            endcase
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= ST_IDLE;
      k_reg          <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wr_reg         <= 1'b0;
      uns_reg        <= 1'b0;
      size_reg       <= '0;
      rvc_reg        <= 1'b0;
      port_reg       <= '0;
      buf_reg        <= '0;
      mem_a_reg      <= '0;
      mem_dout_reg   <= '0;
      mem_wr_reg     <= 1'b0;
      resp_valid_reg <= '0;
      resp_rdata_reg <= '0;
      resp_is_c_reg  <= 1'b0;
    end else if (rdy_in) begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      wr_reg         <= wr_next;
      uns_reg        <= uns_next;
      size_reg       <= size_next;
      rvc_reg        <= rvc_next;
      port_reg       <= port_next;
      buf_reg        <= buf_next;
      mem_a_reg      <= mem_a_next;
      mem_dout_reg   <= mem_dout_next;
      mem_wr_reg     <= mem_wr_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_is_c_reg  <= resp_is_c_next;
    end
  end

  // The accept pulse is combinational from the grant, held off while in reset.
  assign req_ready  = rst_in ? grant : '0;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_is_c  = resp_is_c_reg;
  assign mem_a      = mem_a_reg;
  assign mem_dout   = mem_dout_reg;
  assign mem_wr     = mem_wr_reg;

endmodule

// File: tb/tb_memctrl_mp.sv
// Directed self-checking bench for memctrl_mp with a 1-cycle-latency RAM model.
module tb_memctrl_mp;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_type = '0;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_is_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  ram [0:4095];
  logic [31:0] log_a [$];
  logic [7:0]  log_d [$];
  int          log_c [$];

  memctrl_mp dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_type       (req_type),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_is_c      (resp_is_c)
  );

  always #5 clk_in = ~clk_in;

  // RAM contents are loaded while reset is held; writes are logged with their cycle.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (!rst_in) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
      ram[12'h200] <= 8'h01; ram[12'h201] <= 8'h45;
      ram[12'h202] <= 8'h33; ram[12'h203] <= 8'h22;
      ram[12'h010] <= 8'h80; ram[12'h011] <= 8'hFF;
    end else begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) begin
        ram[mem_a[11:0]] <= mem_dout;
        log_a.push_back(mem_a);
        log_d.push_back(mem_dout);
        log_c.push_back(cyc);
      end
    end
  end

  // Issues one request, optional flush at cycle A+flush_at; lat = -1 if no response.
  task automatic run_txn(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] typ, input int flush_at, output int a_cyc,
                         output int lat, output logic [31:0] rdata, output logic isc,
                         output logic [1:0] rv);
    logic got;
    got = 1'b0; lat = -1; a_cyc = -1; rdata = 'x; isc = 1'bx; rv = 'x;
    @(posedge clk_in); #1;
    req_addr[port*32 +: 32]  = addr;
    req_wdata[port*32 +: 32] = wdata;
    req_type[port*4 +: 4]    = typ;
    req_valid[port]          = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (req_ready[port]) begin got = 1'b1; break; end
    end
    a_cyc = cyc;
    @(posedge clk_in); #1;
    req_valid[port] = 1'b0;
    if (got) begin
      for (int i = 0; i < 40; i++) begin
        flush = (flush_at > 0) && (cyc == a_cyc + flush_at);
        @(negedge clk_in);
        if (resp_valid != 2'b00) begin
          lat = cyc - a_cyc; rdata = resp_rdata; isc = resp_is_c; rv = resp_valid;
          break;
        end
        @(posedge clk_in); #1;
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    repeat (3) @(negedge clk_in);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
    checks++; if (resp_is_c !== 1'b0) begin errors++; $display("FAIL reset_resp_is_c got %b want 0", resp_is_c); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    req_valid = 2'b00;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_word_read();
    int a, lat; logic [31:0] rd; logic c; logic [1:0] rv;
    run_txn(1, 32'h100, 32'h0, 4'b0010, 0, a, lat, rd, c, rv);
    $display("word read p1 @100: lat %0d rdata %h is_c %b", lat, rd, c);
    checks++; if (lat !== 6) begin errors++; $display("FAIL lw_latency got %0d want 6", lat); end
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL lw_resp_port got %b want 10", rv); end
    checks++; if (rd !== 32'h0000_0513) begin errors++; $display("FAIL lw_rdata got %h want 00000513", rd); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL lw_is_c got %b want 0", c); end
  endtask

  task automatic test_rvc();
    int a, lat; logic [31:0] rd; logic c; logic [1:0] rv;
    run_txn(1, 32'h200, 32'h0, 4'b0010, 0, a, lat, rd, c, rv);
    $display("rvc fetch p1 @200: lat %0d rdata %h is_c %b", lat, rd, c);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rvc_latency got %0d want 4", lat); end
    checks++; if (rd !== 32'h0000_4501) begin errors++; $display("FAIL rvc_rdata got %h want 00004501", rd); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL rvc_is_c got %b want 1", c); end
    run_txn(0, 32'h200, 32'h0, 4'b0010, 0, a, lat, rd, c, rv);
    $display("word read p0 @200: lat %0d rdata %h is_c %b", lat, rd, c);
    checks++; if (lat !== 6) begin errors++; $display("FAIL norvc_latency got %0d want 6", lat); end
    checks++; if (rd !== 32'h2233_4501) begin errors++; $display("FAIL norvc_rdata got %h want 22334501", rd); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL norvc_is_c got %b want 0", c); end
  endtask

  task automatic test_extend();
    logic [3:0]  t_tab [4] = '{4'b0001, 4'b0101, 4'b0000, 4'b0100};
    logic [31:0] e_tab [4] = '{32'hFFFF_FF80, 32'h0000_FF80, 32'hFFFF_FF80, 32'h0000_0080};
    int          l_tab [4] = '{4, 4, 3, 3};
    int a, lat; logic [31:0] rd; logic c; logic [1:0] rv;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 32'h10, 32'h0, t_tab[i], 0, a, lat, rd, c, rv);
      $display("load type %b @10: lat %0d rdata %h", t_tab[i], lat, rd);
      checks++; if (rd !== e_tab[i]) begin errors++; $display("FAIL ext_rdata[%0d] got %h want %h", i, rd, e_tab[i]); end
      checks++; if (lat !== l_tab[i]) begin errors++; $display("FAIL ext_latency[%0d] got %0d want %0d", i, lat, l_tab[i]); end
    end
  endtask

  task automatic test_store();
    int a, lat, base; logic [31:0] rd, wd; logic c; logic [1:0] rv;
    wd = 32'hDEAD_BEEF;
    base = log_a.size();
    run_txn(0, 32'h20, wd, 4'b1010, 0, a, lat, rd, c, rv);
    $display("sw p0 @20 data %h: lat %0d writes %0d", wd, lat, log_a.size() - base);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sw_latency got %0d want 5", lat); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL sw_resp_port got %b want 01", rv); end
    checks++; if (log_a.size() - base !== 4) begin errors++; $display("FAIL sw_write_count got %0d want 4", log_a.size() - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_a[base+i] !== 32'h20 + 32'(i) || log_d[base+i] !== 8'(wd >> (8*i)) || log_c[base+i] !== a + 1 + i) begin
        errors++;
        $display("FAIL sw_byte[%0d] got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i, log_a[base+i], log_d[base+i],
                 log_c[base+i], 32'h20 + 32'(i), 8'(wd >> (8*i)), a + 1 + i);
      end
    end
    run_txn(0, 32'h20, 32'h0, 4'b0010, 0, a, lat, rd, c, rv);
    $display("lw p0 @20 readback: rdata %h", rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_readback got %h want deadbeef", rd); end
  endtask

  task automatic test_io_block();
    logic [1:0] first; int early, base; logic got;
    first = 2'b00; early = 0; got = 1'b0; base = log_a.size();
    @(posedge clk_in); #1;
    io_buffer_full = 1'b1;
    req_addr[31:0] = 32'h0003_0000; req_wdata[31:0] = 32'h5A; req_type[3:0] = 4'b1000;
    req_addr[63:32] = 32'h100; req_type[7:4] = 4'b0010;
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (req_ready != 2'b00) begin first = req_ready; break; end
    end
    checks++; if (first !== 2'b10) begin errors++; $display("FAIL io_first_grant got %b want 10", first); end
    @(posedge clk_in); #1;
    req_valid[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (req_ready[0]) early++;
      if (resp_valid[1]) begin got = 1'b1; break; end
    end
    repeat (3) begin
      @(negedge clk_in);
      if (req_ready[0]) early++;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL io_port1_resp got %b want 1", got); end
    checks++; if (early !== 0) begin errors++; $display("FAIL io_blocked_grants got %0d want 0", early); end
    @(posedge clk_in); #1;
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    $display("io store grant after drop: req_ready %b", req_ready);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL io_grant_on_drop got %b want 01", req_ready); end
    @(posedge clk_in); #1;
    req_valid[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (resp_valid[0]) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || log_a.size() - base !== 1 || log_a[base] !== 32'h0003_0000 || log_d[base] !== 8'h5A) begin
      errors++;
      $display("FAIL io_store got resp=%b writes=%0d want resp=1 writes=1 a=30000 d=5a", got, log_a.size() - base);
    end
  endtask

  task automatic test_flush();
    int a, lat, base; logic [31:0] rd; logic c; logic [1:0] rv; logic got;
    base = log_a.size();
    run_txn(1, 32'h100, 32'h0, 4'b0010, 2, a, lat, rd, c, rv);
    $display("read flushed at A+2: lat %0d", lat);
    checks++; if (lat !== -1) begin errors++; $display("FAIL flush_read_resp got lat %0d want none", lat); end
    checks++; if (log_a.size() - base !== 0) begin errors++; $display("FAIL flush_read_mem_wr got %0d writes want 0", log_a.size() - base); end
    @(posedge clk_in); #1;
    req_addr[31:0] = 32'h10; req_type[3:0] = 4'b0000; req_valid[0] = 1'b1; flush = 1'b1;
    @(negedge clk_in);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_grant_suppress got %b want 00", req_ready); end
    @(posedge clk_in); #1;
    flush = 1'b0;
    @(negedge clk_in);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_grant_after got %b want 01", req_ready); end
    @(posedge clk_in); #1;
    req_valid[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (resp_valid[0]) begin got = 1'b1; break; end
    end
    checks++; if (!got || resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL flush_grant_load got %h want ffffff80", resp_rdata); end
    base = log_a.size();
    run_txn(0, 32'h40, 32'h1122_3344, 4'b1010, 2, a, lat, rd, c, rv);
    $display("write flushed at A+2: lat %0d writes %0d", lat, log_a.size() - base);
    checks++; if (lat !== 5) begin errors++; $display("FAIL flush_write_latency got %0d want 5", lat); end
    checks++; if (log_a.size() - base !== 4) begin errors++; $display("FAIL flush_write_count got %0d want 4", log_a.size() - base); end
    checks++;
    if ({ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]} !== 32'h1122_3344) begin
      errors++;
      $display("FAIL flush_write_data got %h want 11223344", {ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] gp [4]; int gc [4]; int rc [4]; int ng, nr;
    logic [1:0] exp_g;
    ng = 0; nr = 0;
    for (int i = 0; i < 4; i++) begin gp[i] = 2'b00; gc[i] = -100; rc[i] = -200; end
    @(posedge clk_in); #1;
    req_addr = {32'h10, 32'h10}; req_type = 8'h00; req_valid = 2'b11;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (req_ready != 2'b00 && ng < 4) begin gp[ng] = req_ready; gc[ng] = cyc; ng++; end
      if (resp_valid != 2'b00 && nr < 4) begin rc[nr] = cyc; nr++; end
      if (ng == 4 && nr >= 3) break;
    end
    @(posedge clk_in); #1;
    req_valid = 2'b00;
    repeat (6) @(posedge clk_in);
    for (int i = 0; i < 4; i++) begin
`ifdef MEMCTRL_RR_ARB_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      $display("b2b grant %0d: port mask %b at cycle %0d", i, gp[i], gc[i]);
      checks++; if (gp[i] !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d] got %b want %b", i, gp[i], exp_g); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rc[i] - gc[i] !== 3) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 3", i, rc[i] - gc[i]); end
      checks++; if (gc[i+1] !== rc[i]) begin errors++; $display("FAIL b2b_gap[%0d] grant cycle %0d want %0d", i, gc[i+1], rc[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_rvc();
    test_extend();
    test_store();
    test_io_block();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memctrl_mp.md
Name: memctrl_mp

Overview:
- Next-generation byte-serial memory controller with N request ports, for example i-fetch, LSB and a future d-prefetch.
- Arbitrates the ports onto the single 8-bit RAM/IO bus and serialises byte, half and word loads and stores.
- Returns a registered, sign- or zero-extended result, and terminates compressed (RVC) fetches early on enabled ports.
- Sits between the front-end/LSB and the top-level mem_* pins.

Parameters:
- NUM_PORTS, 2, number of requesters. Port 0 has the highest fixed priority.
- ADDR_W, 32, request and bus address width.
- RVC_MASK, 2'b10, per-port bit enabling RVC early termination (bit i for port i).
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO space.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable. When low, all state freezes.
- flush  in  1  misprediction clear.
- io_buffer_full  in  1  UART buffer full.
- mem_din  in  8  read data bus.
- mem_dout  out  8  write data bus.
- mem_a  out  ADDR_W  address bus.
- mem_wr  out  1  1 = write.
- req_valid  in  NUM_PORTS  per-port request.
- req_ready  out  NUM_PORTS  one-hot, 1-cycle accept pulse.
- req_addr  in  NUM_PORTS*ADDR_W  packed addresses.
- req_wdata  in  NUM_PORTS*32  packed store data.
- req_type  in  NUM_PORTS*4  packed {wr, unsigned, size[1:0]}. size 00 = byte, 01 = half, 10 = word.
- resp_valid  out  NUM_PORTS  one-hot, 1-cycle completion pulse.
- resp_rdata  out  32  registered load result. Valid with resp_valid, held until the next completion.
- resp_is_c  out  1  completion was a 16-bit RVC fetch.

Behaviour:
- Reset (rst_in low, async): state = IDLE. Outputs reset as follows:
  - req_ready = 0, resp_valid = 0, resp_is_c = 0.
  - mem_wr = 0, mem_a = 0, mem_dout = 0.
  - resp_rdata = 0.
  - arbitration pointer = 0.
- rdy_in low freezes every register. mem_wr is still driven from the held state.
- Request handshake: the requester holds req_valid, addr, wdata and type stable until its req_ready pulse. The controller samples them in the accept cycle A.
- States: IDLE, XFER (byte index k = 0..n-1), WAIT (read-data capture), DONE.
- IDLE: among eligible ports, grant one and pulse its req_ready.
  - A port is ineligible only if it is a write to addr >= IO_BASE while io_buffer_full = 1.
  - Reads, and writes below IO_BASE, are never blocked by io_buffer_full.
- Transfer size: n = 1, 2 or 4 bytes. size 11 is illegal and is treated as a word.
- Write timing: cycles A+1+k drive mem_a = addr+k, mem_dout = wdata byte k, mem_wr = 1. resp_valid pulses at A+n+1.
- Read timing: cycles A+1+k drive mem_a = addr+k, mem_wr = 0. Byte k is sampled from mem_din at cycle A+2+k (1-cycle RAM latency). resp_valid and resp_rdata update at A+n+2.
- Extension: unsigned = 0 sign-extends from the top loaded byte; unsigned = 1 zero-extends. Words are passed through unchanged.
- RVC early termination: applies to word reads on a port with its RVC_MASK bit set.
  - If byte 0 [1:0] != 2'b11, stop after 2 bytes.
  - resp_rdata = {16'b0, byte1, byte0}, resp_is_c = 1, resp_valid at A+4.
  - Otherwise resp_is_c = 0.
- Address arithmetic is ADDR_W wide and wraps at 2^ADDR_W. No alignment checking.
- Back-to-back: the next grant may occur in the cycle resp_valid is high, so the minimum gap is 0 idle cycles.
- Flush:
  - In IDLE: no grant that cycle.
  - During a read: abort immediately to IDLE, no resp_valid, mem_wr stays 0.
  - During a write: the write completes all bytes and its resp_valid still fires, because committed stores must not be torn.
  - flush in the same cycle as a grant: the grant is suppressed.
- Only one transaction is in flight at a time. resp_valid and req_ready are never both high for different ports in a way that breaks one-hot encoding.

Optional Feature:
- MEMCTRL_RR_ARB_EN defined: round-robin arbitration. The pointer advances to the port after the last granted one. No port starves while others request.
- Undefined: fixed priority, lowest index wins. Pointer logic is removed.

Decomposition:
- Package memctrl_pkg:
  - type-field encodings (SZ_B/SZ_H/SZ_W, TYPE_WR_BIT, TYPE_UNS_BIT)
  - state enum
  - IO_BASE default
  - helper function for the byte count of a size
- Sub-module mem_rr_arbiter: NUM_PORTS request mask in, one-hot grant out. Round-robin or fixed priority under the macro.

Test Plan:
- Port1 word read at 0x100, RAM holds 13 05 00 00 at 0x100-0x103 -> req_ready[1] at A, resp_valid[1] at A+6, resp_rdata = 0x00000513, resp_is_c = 0.
- Port1 word read at 0x200, RAM holds 01 45 at 0x200-0x201 (byte0 [1:0] = 01) -> only 2 bytes fetched, resp_valid[1] at A+4, resp_rdata = 0x00004501, resp_is_c = 1.
- Port0 lh at 0x10 holding 0x80 0xFF with unsigned = 0 -> 0xFFFFFF80. The same load with unsigned = 1 -> 0x0000FF80.
- Port0 sw 0xDEADBEEF to 0x20 -> mem_wr high for 4 cycles with addrs 0x20-0x23 and dout EF, BE, AD, DE; resp_valid[0] at A+5.
- io_buffer_full = 1 with port0 sb to 0x30000 and port1 read pending -> port1 granted first, port0 granted on the first cycle after io_buffer_full drops.
- flush asserted at A+2 of a read -> no resp_valid. flush at A+2 of a word write -> all 4 bytes written and resp_valid at A+5.
- With MEMCTRL_RR_ARB_EN, both ports continuously requesting -> grants alternate 0, 1, 0, 1.
